// File: rtl/rt_ibex_pcs_bus_spill.sv
// Bus-backed preserved context stack: spills a packed frame to data memory on
// interrupt ack and fills it back for mret, one outstanding bus word at a time.
module rt_ibex_pcs_bus_spill #(
  parameter int unsigned NrSavedRegs   = 18,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned MaxDepth      = 16,
  parameter int unsigned IrqLevelWidth = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [IrqLevelWidth-1:0]           irq_level_i,
  input  logic                               irq_ack_i,
  input  logic                               irq_exit_i,
  input  logic                               next_mret_i,
  input  logic [NrSavedRegs*DataWidth-1:0]   store_data_i,
  output logic [NrSavedRegs*DataWidth-1:0]   restore_data_o,
  output logic                               restore_en_o,
  output logic                               busy_o,
  input  logic [31:0]                        base_addr_i,
  output logic [$clog2(MaxDepth+1)-1:0]      depth_o,
  output logic                               overflow_o,
  output logic                               bus_err_o,
  output logic                               data_req_o,
  output logic                               data_we_o,
  output logic [31:0]                        data_addr_o,
  output logic [31:0]                        data_wdata_o,
  output logic [3:0]                         data_be_o,
  input  logic                               data_gnt_i,
  input  logic                               data_rvalid_i,
  input  logic                               data_err_i,
  input  logic [31:0]                        data_rdata_i
);

  // state   | meaning
  // S_IDLE  | no transfer, stack at rest
  // S_SPILL | writing the snapshot frame to memory
  // S_FILL  | reading the top frame back from memory
  // S_READY | filled frame valid, waiting for mret to retire
  localparam int unsigned DepthW = $clog2(MaxDepth + 1);
  localparam int unsigned IdxW   = $clog2(NrSavedRegs + 1);

  typedef enum logic [1:0] {S_IDLE, S_SPILL, S_FILL, S_READY} state_e;

  state_e                          r_state, w_state_nxt;
  logic [NrSavedRegs*DataWidth-1:0] r_snap, r_restore;
  logic [31:0]                     r_base;
  logic [DepthW-1:0]               r_depth;
  logic [IdxW-1:0]                 r_idx;
  logic r_wait, r_preempt, r_pend, r_restore_en, r_overflow, r_bus_err;
  logic w_xfer, w_req, w_rsp, w_last, w_full, w_ack_ok, w_ovf;
  logic w_start, w_push, w_pop;
  logic [DepthW-1:0]               w_frame;
  logic [31:0]                     w_word_off;

  assign w_xfer   = (r_state == S_SPILL) || (r_state == S_FILL);
  assign w_req    = w_xfer && !r_wait;
  assign w_rsp    = w_xfer && r_wait && data_rvalid_i;
  assign w_last   = (r_idx == IdxW'(NrSavedRegs - 1));
  assign w_full   = (r_depth == DepthW'(MaxDepth));
  assign w_ack_ok = irq_ack_i && !w_full && (r_state != S_SPILL);
  assign w_ovf    = irq_ack_i && w_full && (r_state != S_SPILL);

  // Spill writes the next free frame, fill reads the top one.
  assign w_frame    = (r_state == S_SPILL) ? r_depth : r_depth - 1'b1;
  assign w_word_off = 32'(w_frame) * NrSavedRegs + 32'(r_idx);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ack_ok) begin
          w_state_nxt = S_SPILL;
          w_start     = 1'b1;
        end else if ((next_mret_i || irq_exit_i) && r_depth != '0) begin
          w_state_nxt = S_FILL;
          w_start     = 1'b1;
        end
      end
      S_SPILL: begin
        if (w_rsp && w_last) begin
          w_state_nxt = S_IDLE;
          w_push      = 1'b1;
        end
      end
      S_FILL: begin
        if (w_rsp) begin
          if (r_preempt || w_ack_ok) begin
            w_state_nxt = S_SPILL;
            w_start     = 1'b1;
          end else if (w_last) begin
            if (r_pend || irq_exit_i) begin
              w_state_nxt = S_IDLE;
              w_pop       = 1'b1;
            end else begin
              w_state_nxt = S_READY;
            end
          end
        end
      end
      S_READY: begin
        if (w_ack_ok) begin
          w_state_nxt = S_SPILL;
          w_start     = 1'b1;
        end else if (irq_exit_i) begin
          w_state_nxt = S_IDLE;
          w_pop       = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_snap       <= '0;
      r_restore    <= '0;
      r_base       <= '0;
      r_depth      <= '0;
      r_idx        <= '0;
      r_wait       <= 1'b0;
      r_preempt    <= 1'b0;
      r_pend       <= 1'b0;
      r_restore_en <= 1'b0;
      r_overflow   <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_restore_en <= w_pop;
      if (w_ack_ok) begin
        r_snap <= store_data_i;
        r_base <= base_addr_i;
      end
      if (w_start) begin
        r_idx     <= '0;
        r_wait    <= 1'b0;
        r_preempt <= 1'b0;
      end else begin
        if (w_req && data_gnt_i) r_wait <= 1'b1;
        if (w_rsp) begin
          r_wait <= 1'b0;
          r_idx  <= r_idx + 1'b1;
        end
        // An ack mid-word must let that word complete before spilling.
        if (r_state == S_FILL && w_ack_ok) r_preempt <= 1'b1;
      end
      if (r_state == S_FILL && w_rsp && !r_preempt && !w_ack_ok)
        r_restore[r_idx*DataWidth +: DataWidth] <= data_rdata_i;
      if (w_pop || (w_start && w_state_nxt == S_SPILL))
        r_pend <= 1'b0;
      else if (irq_exit_i && ((r_state == S_IDLE && r_depth != '0) || r_state == S_FILL))
        r_pend <= 1'b1;
      if (w_push)     r_depth <= r_depth + 1'b1;
      else if (w_pop) r_depth <= r_depth - 1'b1;
      if (w_ovf) r_overflow <= 1'b1;
      if (data_rvalid_i && data_err_i) r_bus_err <= 1'b1;
    end
  end

  assign restore_data_o = r_restore;
  assign restore_en_o   = r_restore_en;
  assign busy_o         = w_xfer;
  assign depth_o        = r_depth;
  assign overflow_o     = r_overflow;
  assign bus_err_o      = r_bus_err;
  assign data_req_o     = w_req;
  assign data_we_o      = w_req && (r_state == S_SPILL);
  assign data_addr_o    = w_req ? r_base + {w_word_off[29:0], 2'b00} : 32'd0;
  assign data_wdata_o   = (w_req && r_state == S_SPILL) ? r_snap[r_idx*DataWidth +: DataWidth] : 32'd0;
  assign data_be_o      = 4'hF;

  // The core must hold off a second ack until the spill drains.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(irq_ack_i && r_state == S_SPILL));
  assert property (@(posedge clk_i) disable iff (!rst_ni) irq_ack_i |-> !$isunknown(irq_level_i));

endmodule

// File: tb/tb_rt_ibex_pcs_bus_spill.sv
// Directed bench for rt_ibex_pcs_bus_spill with a one-outstanding memory responder.
module tb_rt_ibex_pcs_bus_spill;
  localparam int N  = 18;
  localparam int MD = 2;
  localparam int FW = N * 32;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [7:0]    irq_level_i;
  logic          irq_ack_i, irq_exit_i, next_mret_i;
  logic [FW-1:0] store_data_i, restore_data_o;
  logic          restore_en_o, busy_o;
  logic [31:0]   base_addr_i;
  logic [1:0]    depth_o;
  logic          overflow_o, bus_err_o, data_req_o, data_we_o;
  logic [31:0]   data_addr_o, data_wdata_o, data_rdata_i;
  logic [3:0]    data_be_o;
  logic          data_gnt_i, data_rvalid_i, data_err_i;

  always #5 clk_i = ~clk_i;

  rt_ibex_pcs_bus_spill #(.NrSavedRegs(N), .DataWidth(32), .MaxDepth(MD), .IrqLevelWidth(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .irq_level_i(irq_level_i), .irq_ack_i(irq_ack_i),
    .irq_exit_i(irq_exit_i), .next_mret_i(next_mret_i), .store_data_i(store_data_i),
    .restore_data_o(restore_data_o), .restore_en_o(restore_en_o), .busy_o(busy_o),
    .base_addr_i(base_addr_i), .depth_o(depth_o), .overflow_o(overflow_o),
    .bus_err_o(bus_err_o), .data_req_o(data_req_o), .data_we_o(data_we_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o), .data_be_o(data_be_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
    .data_rdata_i(data_rdata_i)
  );

  int total = 0;
  int bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory responder: stalls grant by gnt_stall cycles, rvalid one cycle after grant.
  logic [31:0] mem [64];
  logic [31:0] tx_addr [512];
  logic        tx_we [512];
  logic [31:0] tx_wdata [512];
  int ntx = 0;
  int gnt_stall = 0;
  int err_at = -1;
  int stall_cnt = 0;
  int rsp_tx = 0;
  logic rsp_pend = 1'b0;
  logic [31:0] rsp_addr = '0;

  initial begin
    data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0; data_rdata_i = '0;
    forever begin
      @(posedge clk_i); #1;
      data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0; data_rdata_i = '0;
      if (!rst_ni) begin
        rsp_pend = 0; stall_cnt = 0;
      end else if (rsp_pend) begin
        data_rvalid_i = 1;
        data_rdata_i  = mem[rsp_addr[7:2]];
        data_err_i    = (rsp_tx == err_at);
        rsp_pend      = 0;
      end else if (data_req_o) begin
        if (stall_cnt < gnt_stall) stall_cnt++;
        else begin
          data_gnt_i = 1; stall_cnt = 0;
          if (ntx < 512) begin
            tx_addr[ntx] = data_addr_o; tx_we[ntx] = data_we_o; tx_wdata[ntx] = data_wdata_o;
          end
          if (data_we_o) mem[data_addr_o[7:2]] = data_wdata_o;
          rsp_pend = 1; rsp_addr = data_addr_o; rsp_tx = ntx; ntx++;
        end
      end
    end
  end

  int n_restore = 0;
  logic [FW-1:0] cap = '0;
  always @(negedge clk_i) if (restore_en_o) begin
    n_restore++;
    cap = restore_data_o;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_o && n < 2000) begin tick(); n++; end
    check_val(tag, {31'd0, busy_o}, 32'd0);
  endtask

  function automatic logic [FW-1:0] mk_frame(input logic [31:0] b);
    logic [FW-1:0] f;
    for (int i = 0; i < N; i++) f[i*32 +: 32] = b + 32'(i);
    return f;
  endfunction

  task automatic do_ack(input logic [31:0] b);
    store_data_i = mk_frame(b); base_addr_i = BASE; irq_ack_i = 1;
    tick();
    irq_ack_i = 0; store_data_i = '1; base_addr_i = 32'hDEAD_BEE0;
  endtask

  task automatic pulse_exit();
    irq_exit_i = 1; tick(); irq_exit_i = 0;
  endtask

  task automatic pulse_mret();
    next_mret_i = 1; tick(); next_mret_i = 0;
  endtask

  task automatic check_txns(input string tag, input int t0, input logic we,
                            input logic [31:0] a0, input logic [31:0] d0);
    for (int i = 0; i < N; i++) begin
      check_val({tag, "_addr"}, tx_addr[t0+i], a0 + 32'(4*i));
      check_val({tag, "_we"}, {31'd0, tx_we[t0+i]}, {31'd0, we});
      if (we) check_val({tag, "_data"}, tx_wdata[t0+i], d0 + 32'(i));
    end
  endtask

  int t0, r0;

  initial begin
    irq_level_i = 8'd3; irq_ack_i = 0; irq_exit_i = 0; next_mret_i = 0;
    store_data_i = '0; base_addr_i = BASE;
    rst_ni = 0;
    repeat (3) @(posedge clk_i);
    #1;
    check_val("rst_depth", 32'(depth_o), 0);
    check_val("rst_busy", {31'd0, busy_o}, 0);
    check_val("rst_req", {31'd0, data_req_o}, 0);
    check_val("rst_restore_en", {31'd0, restore_en_o}, 0);
    check_val("rst_ovf", {31'd0, overflow_o}, 0);
    check_val("rst_err", {31'd0, bus_err_o}, 0);
    check_val("rst_rdata", {31'd0, |restore_data_o}, 0);
    rst_ni = 1;
    tick();

    // single spill
    t0 = ntx;
    do_ack(32'hA0);
    check_val("spill_busy", {31'd0, busy_o}, 1);
    check_val("spill_first_req", {31'd0, data_req_o}, 1);
    check_val("spill_be", 32'(data_be_o), 32'hF);
    wait_idle("spill_done");
    check_val("spill_ntx", 32'(ntx - t0), 18);
    check_txns("spill", t0, 1'b1, BASE, 32'hA0);
    check_val("spill_depth", 32'(depth_o), 1);

    // prefetch fill then pop
    t0 = ntx; r0 = n_restore;
    pulse_mret();
    wait_idle("fill_done");
    check_val("fill_no_pulse", 32'(n_restore - r0), 0);
    check_val("fill_word5", restore_data_o[5*32 +: 32], 32'hA5);
    check_val("fill_depth", 32'(depth_o), 1);
    check_txns("fill", t0, 1'b0, BASE, 32'h0);
    pulse_exit();
    check_val("pop_en", {31'd0, restore_en_o}, 1);
    check_val("pop_depth", 32'(depth_o), 0);
    tick();
    check_val("pop_en_low", {31'd0, restore_en_o}, 0);
    check_val("pop_pulses", 32'(n_restore - r0), 1);

    // nesting
    do_ack(32'hA0);
    wait_idle("nest1_done");
    t0 = ntx;
    do_ack(32'hB0);
    wait_idle("nest2_done");
    check_txns("nest2", t0, 1'b1, BASE + 32'h48, 32'hB0);
    check_val("nest_depth", 32'(depth_o), 2);

    // overflow at full depth
    t0 = ntx;
    do_ack(32'hD0);
    repeat (5) tick();
    check_val("ovf_flag", {31'd0, overflow_o}, 1);
    check_val("ovf_depth", 32'(depth_o), 2);
    check_val("ovf_no_bus", 32'(ntx - t0), 0);
    check_val("ovf_busy", {31'd0, busy_o}, 0);

    // pending pop from idle returns frame 2
    t0 = ntx; r0 = n_restore;
    pulse_exit();
    wait_idle("pop2_done");
    tick();
    check_val("pop2_pulses", 32'(n_restore - r0), 1);
    check_val("pop2_w0", cap[0 +: 32], 32'hB0);
    check_val("pop2_w17", cap[17*32 +: 32], 32'hC1);
    check_val("pop2_addr", tx_addr[t0], BASE + 32'h48);
    check_val("pop2_depth", 32'(depth_o), 1);

    // prefetched pop returns frame 1
    r0 = n_restore;
    pulse_mret();
    wait_idle("pop1_fill");
    pulse_exit();
    tick();
    check_val("pop1_pulses", 32'(n_restore - r0), 1);
    check_val("pop1_w5", cap[5*32 +: 32], 32'hA5);
    check_val("pop1_depth", 32'(depth_o), 0);

    // preemption of a fill stalled on grant
    do_ack(32'hA0);
    wait_idle("pre_base");
    gnt_stall = 3; t0 = ntx; r0 = n_restore;
    pulse_mret();
    tick();
    check_val("pre_req_stalled", {31'd0, data_req_o}, 1);
    do_ack(32'hC0);
    wait_idle("pre_done");
    check_val("pre_ntx", 32'(ntx - t0), 19);
    check_val("pre_rd_we", {31'd0, tx_we[t0]}, 0);
    check_val("pre_rd_addr", tx_addr[t0], BASE);
    check_txns("pre_spill", t0 + 1, 1'b1, BASE + 32'h48, 32'hC0);
    check_val("pre_no_pulse", 32'(n_restore - r0), 0);
    check_val("pre_depth", 32'(depth_o), 2);
    r0 = n_restore;
    pulse_exit();
    wait_idle("pre_pop");
    tick();
    check_val("pre_pop_pulses", 32'(n_restore - r0), 1);
    check_val("pre_pop_w0", cap[0 +: 32], 32'hC0);
    check_val("pre_pop_depth", 32'(depth_o), 1);
    gnt_stall = 0;
    pulse_exit();
    wait_idle("pre_pop_last");
    tick();
    check_val("last_w5", cap[5*32 +: 32], 32'hA5);
    check_val("last_depth", 32'(depth_o), 0);

    // exit on empty stack
    t0 = ntx; r0 = n_restore;
    pulse_exit();
    repeat (3) tick();
    check_val("empty_pulses", 32'(n_restore - r0), 0);
    check_val("empty_busy", {31'd0, busy_o}, 0);
    check_val("empty_no_bus", 32'(ntx - t0), 0);
    check_val("empty_depth", 32'(depth_o), 0);

    // bus error on word 3
    t0 = ntx; err_at = ntx + 3;
    check_val("err_before", {31'd0, bus_err_o}, 0);
    do_ack(32'hE0);
    wait_idle("err_done");
    check_val("err_flag", {31'd0, bus_err_o}, 1);
    check_val("err_ntx", 32'(ntx - t0), 18);
    check_val("err_depth", 32'(depth_o), 1);

    // reset mid-spill
    do_ack(32'hF0);
    repeat (4) tick();
    check_val("rst_mid_busy_pre", {31'd0, busy_o}, 1);
    rst_ni = 0;
    #1;
    check_val("rstm_busy", {31'd0, busy_o}, 0);
    check_val("rstm_req", {31'd0, data_req_o}, 0);
    check_val("rstm_we", {31'd0, data_we_o}, 0);
    check_val("rstm_addr", data_addr_o, 0);
    check_val("rstm_wdata", data_wdata_o, 0);
    check_val("rstm_depth", 32'(depth_o), 0);
    check_val("rstm_ovf", {31'd0, overflow_o}, 0);
    check_val("rstm_err", {31'd0, bus_err_o}, 0);
    check_val("rstm_en", {31'd0, restore_en_o}, 0);
    check_val("rstm_rdata", {31'd0, |restore_data_o}, 0);
    tick();
    rst_ni = 1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
